// File: rtl/reg_file_sb.sv
// Register file with two read ports, two write ports and a per-register busy scoreboard.
// Optional define REG_FILE_SB_BYPASS_EN forwards same-cycle write data and busy clears to the read ports.
module reg_file_sb #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic                     BUSY1,
    output logic                     BUSY2,
    input  logic                     WE3,
    input  logic                     WE4,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [ADDRESS_WIDTH-1:0] AD4,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic [DATA_WIDTH-1:0]    WD4,
    input  logic                     ISSUE,
    input  logic [ADDRESS_WIDTH-1:0] ISSUE_AD,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     IDLE
);

    localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic wr3_c;
    logic wr4_c;
    logic iss_c;

    assign wr3_c = WE3 && (AD3 != '0);
    assign wr4_c = WE4 && (AD4 != '0);
    assign iss_c = ISSUE && (ISSUE_AD != '0);

    // Next array state: port 4 is younger, so it is applied last and wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (wr3_c) regs_d[AD3] = WD3;
        if (wr4_c) regs_d[AD4] = WD4;
        regs_d[0] = '0;
    end

    // Writes retire their producer; a same-edge issue is the newer producer and re-sets the bit.
    always_comb begin
        busy_d = busy_q;
        if (wr3_c) busy_d[AD3] = 1'b0;
        if (wr4_c) busy_d[AD4] = 1'b0;
        if (iss_c) busy_d[ISSUE_AD] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] rd_fwd(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = regs_q[addr];
        if (addr != '0) begin
            if (WE3 && (AD3 == addr)) val = WD3;
            if (WE4 && (AD4 == addr)) val = WD4;
        end
        return val;
    endfunction

    // A write in flight clears busy unless the same register is re-issued this cycle.
    function automatic logic busy_fwd(input logic [ADDRESS_WIDTH-1:0] addr);
        logic hit_wr;
        logic hit_iss;
        hit_wr  = (addr != '0) && ((WE3 && (AD3 == addr)) || (WE4 && (AD4 == addr)));
        hit_iss = (addr != '0) && ISSUE && (ISSUE_AD == addr);
        return hit_wr ? hit_iss : busy_q[addr];
    endfunction

    assign RD1   = rd_fwd(AD1);
    assign RD2   = rd_fwd(AD2);
    assign a0    = rd_fwd(A0_ADDR);
    assign BUSY1 = busy_fwd(AD1);
    assign BUSY2 = busy_fwd(AD2);
`else
    assign RD1   = regs_q[AD1];
    assign RD2   = regs_q[AD2];
    assign a0    = regs_q[A0_ADDR];
    assign BUSY1 = busy_q[AD1];
    assign BUSY2 = busy_q[AD2];
`endif

    assign IDLE = ~|busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_reg_file_sb;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef enum int {S_RD1, S_RD2, S_A0, S_BUSY1, S_BUSY2, S_IDLE} sig_e;

    typedef struct {
        string        name;
        sig_e         sig;
        logic [DW-1:0] exp;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] AD1, AD2, AD3, AD4, ISSUE_AD;
    logic [DW-1:0] RD1, RD2, WD3, WD4, a0;
    logic          BUSY1, BUSY2, WE3, WE4, ISSUE, IDLE;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10)) dut (
        .clk(clk), .rst(rst),
        .AD1(AD1), .AD2(AD2), .RD1(RD1), .RD2(RD2),
        .BUSY1(BUSY1), .BUSY2(BUSY2),
        .WE3(WE3), .WE4(WE4), .AD3(AD3), .AD4(AD4), .WD3(WD3), .WD4(WD4),
        .ISSUE(ISSUE), .ISSUE_AD(ISSUE_AD),
        .a0(a0), .IDLE(IDLE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string name, input sig_e sig, input logic [DW-1:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WE3 = 1'b0; WE4 = 1'b0; ISSUE = 1'b0;
        AD3 = '0; AD4 = '0; WD3 = '0; WD4 = '0; ISSUE_AD = '0;
    endtask

    // Monitor: at each negedge, compare every expectation queued for this cycle.
    initial begin
        exp_t          e;
        logic [DW-1:0] act;
        n_vec = 0;
        n_err = 0;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.sig)
                    S_RD1:   act = RD1;
                    S_RD2:   act = RD2;
                    S_A0:    act = a0;
                    S_BUSY1: act = DW'(BUSY1);
                    S_BUSY2: act = DW'(BUSY2);
                    default: act = DW'(IDLE);
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; AD1 = '0; AD2 = '0;
        idle_inputs();
        step();

        // Reset state
        rst = 1'b0; AD1 = 5'd5; AD2 = 5'd31;
        expect_val("rst_rd1",  S_RD1, 32'h0);
        expect_val("rst_rd2",  S_RD2, 32'h0);
        expect_val("rst_a0",   S_A0, 32'h0);
        expect_val("rst_idle", S_IDLE, 32'h1);
        expect_val("rst_busy1", S_BUSY1, 32'h0);
        expect_val("rst_busy2", S_BUSY2, 32'h0);
        step();

        // Write to the a0 mirror register
        WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'hDEADBEEF; AD1 = 5'd10;
        expect_val("wr10_same_rd1", S_RD1, BYP ? 32'hDEADBEEF : 32'h0);
        expect_val("wr10_same_a0",  S_A0,  BYP ? 32'hDEADBEEF : 32'h0);
        step();
        idle_inputs();
        expect_val("wr10_next_a0",  S_A0,  32'hDEADBEEF);
        expect_val("wr10_next_rd1", S_RD1, 32'hDEADBEEF);
        step();

        // Same-address dual write: port 4 wins
        WE3 = 1'b1; AD3 = 5'd7; WD3 = 32'h11;
        WE4 = 1'b1; AD4 = 5'd7; WD4 = 32'h22; AD2 = 5'd7;
        expect_val("dual_same_rd2", S_RD2, BYP ? 32'h22 : 32'h0);
        step();
        idle_inputs(); AD1 = 5'd7;
        expect_val("dual_rd1", S_RD1, 32'h22);
        expect_val("dual_a0_kept", S_A0, 32'hDEADBEEF);
        step();

        // Write to register 0 is dropped
        WE3 = 1'b1; AD3 = 5'd0; WD3 = 32'h55; AD1 = 5'd0;
        expect_val("r0_same_rd1", S_RD1, 32'h0);
        step();
        idle_inputs();
        expect_val("r0_rd1", S_RD1, 32'h0);
        step();

        // Issue to register 0 never sets busy
        ISSUE = 1'b1; ISSUE_AD = 5'd0;
        step();
        idle_inputs();
        expect_val("iss0_busy1", S_BUSY1, 32'h0);
        expect_val("iss0_idle",  S_IDLE,  32'h1);
        step();

        // Issue then retire register 3
        ISSUE = 1'b1; ISSUE_AD = 5'd3; AD1 = 5'd3;
        expect_val("iss3_same_busy1", S_BUSY1, 32'h0);
        expect_val("iss3_same_idle",  S_IDLE,  32'h1);
        step();
        idle_inputs();
        expect_val("iss3_busy1", S_BUSY1, 32'h1);
        expect_val("iss3_idle",  S_IDLE,  32'h0);
        step();
        WE4 = 1'b1; AD4 = 5'd3; WD4 = 32'h33;
        expect_val("wr3_same_busy1", S_BUSY1, BYP ? 32'h0 : 32'h1);
        expect_val("wr3_same_rd1",   S_RD1,   BYP ? 32'h33 : 32'h0);
        step();
        idle_inputs();
        expect_val("wr3_busy1", S_BUSY1, 32'h0);
        expect_val("wr3_idle",  S_IDLE,  32'h1);
        expect_val("wr3_rd1",   S_RD1,   32'h33);
        step();

        // Same-edge issue and write while busy: data lands, busy stays
        ISSUE = 1'b1; ISSUE_AD = 5'd4; AD1 = 5'd4;
        step();
        ISSUE = 1'b1; ISSUE_AD = 5'd4; WE3 = 1'b1; AD3 = 5'd4; WD3 = 32'h9;
        expect_val("iw4_same_busy1", S_BUSY1, 32'h1);
        step();
        idle_inputs();
        expect_val("iw4_rd1",   S_RD1,   32'h9);
        expect_val("iw4_busy1", S_BUSY1, 32'h1);
        expect_val("iw4_idle",  S_IDLE,  32'h0);
        step();

        // Issue 6, then reset with a colliding write
        ISSUE = 1'b1; ISSUE_AD = 5'd6; AD1 = 5'd6; AD2 = 5'd4;
        step();
        idle_inputs();
        rst = 1'b1; WE3 = 1'b1; AD3 = 5'd6; WD3 = 32'h66;
        expect_val("pre_rst_busy1", S_BUSY1, BYP ? 32'h0 : 32'h1);
        step();
        rst = 1'b0; idle_inputs();
        expect_val("post_rst_rd1",   S_RD1,   32'h0);
        expect_val("post_rst_rd2",   S_RD2,   32'h0);
        expect_val("post_rst_busy1", S_BUSY1, 32'h0);
        expect_val("post_rst_busy2", S_BUSY2, 32'h0);
        expect_val("post_rst_idle",  S_IDLE,  32'h1);
        expect_val("post_rst_a0",    S_A0,    32'h0);
        step();

        @(negedge clk);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
